// File: rtl/last_instr_history_pkg.sv
// Shared defaults and the age-to-slot wrap helper for the instruction history buffer.
// Optional feature macro consumed by the top level: LAST_INSTR_BYPASS_EN.
package last_instr_pkg;

  localparam int LAST_INSTR_WIDTH = 49;
  localparam int LAST_INSTR_DEPTH = 4;

  // Physical slot of the entry 'age' writes back from 'ptr'; depth need not be a power of two.
  function automatic int unsigned age_to_slot(input int unsigned ptr,
                                              input int unsigned age,
                                              input int unsigned depth);
    int unsigned s;
    if (age >= depth || ptr >= depth) begin
      return 0;
    end
    s = ptr + depth - 1 - age;
    if (s >= depth) begin
      s = s - depth;
    end
    return s;
  endfunction

endpackage

// File: rtl/last_instr_history_if.sv
// Bus bundle between the pipeline-side user (master) and the history buffer (slave).
interface last_instr_if
  import last_instr_pkg::*;
#(
  parameter int WIDTH = LAST_INSTR_WIDTH,
  parameter int DEPTH = LAST_INSTR_DEPTH
);
  localparam int IDXW = $clog2(DEPTH);

  logic             write_enable;
  logic [WIDTH-1:0] write_data;
  logic             flush;
  logic [IDXW-1:0]  rd_index;
  logic [WIDTH-1:0] read_data;
  logic             read_valid;
  logic [IDXW:0]    count;
  logic             full;

  modport master (
    output write_enable, write_data, flush, rd_index,
    input  read_data, read_valid, count, full
  );

  modport slave (
    input  write_enable, write_data, flush, rd_index,
    output read_data, read_valid, count, full
  );
endinterface

// File: rtl/last_instr_history_mem.sv
// DEPTH x WIDTH history storage: synchronous write, combinational read by slot, async clear.
module last_instr_mem #(
  parameter int WIDTH = 49,
  parameter int DEPTH = 4,
  localparam int IDXW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we_i,
  input  logic [IDXW-1:0]  waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [IDXW-1:0]  raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] entries [DEPTH];

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    logic [WIDTH-1:0] entry_q;

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        entry_q <= '0;
      end else if (we_i && (waddr_i == IDXW'(gi))) begin
        entry_q <= wdata_i;
      end
    end

    assign entries[gi] = entry_q;
  end

  // Slot codes past DEPTH-1 exist when DEPTH is not a power of two.
  assign rdata_o = (32'(raddr_i) < 32'(DEPTH)) ? entries[raddr_i] : '0;

endmodule

// File: rtl/last_instr_history.sv
// History of the last DEPTH instruction words, readable by age with a registered read port.
// Define LAST_INSTR_BYPASS_EN for write-through forwarding of same-cycle writes to the read port.
module last_instr_history
  import last_instr_pkg::*;
#(
  parameter int WIDTH = LAST_INSTR_WIDTH,
  parameter int DEPTH = LAST_INSTR_DEPTH
) (
  input logic        clk,
  input logic        reset,
  last_instr_if.slave bus
);

  localparam int IDXW = $clog2(DEPTH);
  localparam int CW   = IDXW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [IDXW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] read_data_q, read_data_d;
  logic             read_valid_q, read_valid_d;

  logic [IDXW-1:0]  lookup_ptr;
  logic [CW-1:0]    lookup_cnt;
  logic [IDXW-1:0]  rd_slot;
  logic             lookup_valid;
  logic [WIDTH-1:0] mem_rdata;

  last_instr_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk     (clk),
    .reset   (reset),
    .we_i    (bus.write_enable),
    .waddr_i (wr_ptr_q),
    .wdata_i (bus.write_data),
    .raddr_i (rd_slot),
    .rdata_o (mem_rdata)
  );

  // Flush clears occupancy first, so a same-cycle write leaves exactly one entry.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (bus.flush) begin
      count_d = '0;
    end
    if (bus.write_enable) begin
      wr_ptr_d = (wr_ptr_q == IDXW'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
      if (bus.flush) begin
        count_d = CW'(1);
      end else if (count_q != DEPTH_C) begin
        count_d = count_q + 1'b1;
      end
    end
  end

  always_comb begin
    lookup_ptr = wr_ptr_q;
    lookup_cnt = count_q;
`ifdef LAST_INSTR_BYPASS_EN
    // Ages are taken against the post-write history; age 0 is forwarded below.
    if (bus.write_enable) begin
      lookup_ptr = wr_ptr_d;
      lookup_cnt = count_d;
    end
`endif
    rd_slot      = IDXW'(age_to_slot(32'(lookup_ptr), 32'(bus.rd_index), 32'(DEPTH)));
    lookup_valid = ({1'b0, bus.rd_index} < lookup_cnt);
  end

  always_comb begin
    read_valid_d = lookup_valid;
    read_data_d  = lookup_valid ? mem_rdata : '0;
`ifdef LAST_INSTR_BYPASS_EN
    if (bus.write_enable && (bus.rd_index == '0)) begin
      read_valid_d = 1'b1;
      read_data_d  = bus.write_data;
    end else if (bus.flush && !bus.write_enable) begin
      read_valid_d = 1'b0;
      read_data_d  = '0;
    end
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q     <= '0;
      count_q      <= '0;
      read_data_q  <= '0;
      read_valid_q <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      count_q      <= count_d;
      read_data_q  <= read_data_d;
      read_valid_q <= read_valid_d;
    end
  end

  assign bus.read_data  = read_data_q;
  assign bus.read_valid = read_valid_q;
  assign bus.count      = count_q;
  assign bus.full       = (count_q == DEPTH_C);

endmodule

// File: tb/tb_last_instr_history.sv
// Scoreboard bench for last_instr_history: DEPTH=4 and DEPTH=3 instances, directed vectors.
module tb_last_instr_history;
  import last_instr_pkg::*;

`ifdef LAST_INSTR_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  typedef struct {
    int          idx;
    bit          v;
    logic [48:0] d;
    int          cnt;
  } exp_t;

  logic clk;
  logic reset;
  int   checks   = 0;
  int   failures = 0;
  exp_t q4[$];
  exp_t q3[$];

  last_instr_if #(.WIDTH(49), .DEPTH(4)) bus4 ();
  last_instr_if #(.WIDTH(49), .DEPTH(3)) bus3 ();

  last_instr_history #(.WIDTH(49), .DEPTH(4)) dut4 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus4.slave)
  );

  last_instr_history #(.WIDTH(49), .DEPTH(3)) dut3 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus3.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic cyc4(input bit we, input logic [48:0] wd, input bit fl, input int idx,
                      input bit ev, input logic [48:0] ed, input int ecnt);
    @(negedge clk);
    bus4.write_enable = we;
    bus4.write_data   = wd;
    bus4.flush        = fl;
    bus4.rd_index     = 2'(idx);
    q4.push_back(exp_t'{idx, ev, ed, ecnt});
  endtask

  task automatic cyc3(input bit we, input logic [48:0] wd, input int idx,
                      input bit ev, input logic [48:0] ed, input int ecnt);
    @(negedge clk);
    bus3.write_enable = we;
    bus3.write_data   = wd;
    bus3.flush        = 1'b0;
    bus3.rd_index     = 2'(idx);
    q3.push_back(exp_t'{idx, ev, ed, ecnt});
  endtask

  initial begin : mon4
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q4.size() > 0) begin
        e = q4.pop_front();
        chk("d4_read_valid", 64'(bus4.read_valid), 64'(e.v));
        chk("d4_read_data",  64'(bus4.read_data),  64'(e.d));
        chk("d4_count",      64'(bus4.count),      64'(e.cnt));
        chk("d4_full",       64'(bus4.full),       64'(e.cnt == 4));
        $display("txn d4 idx=%0d valid=%0b data=0x%0h count=%0d", e.idx,
                 bus4.read_valid, bus4.read_data, bus4.count);
      end
    end
  end

  initial begin : mon3
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q3.size() > 0) begin
        e = q3.pop_front();
        chk("d3_read_valid", 64'(bus3.read_valid), 64'(e.v));
        chk("d3_read_data",  64'(bus3.read_data),  64'(e.d));
        chk("d3_count",      64'(bus3.count),      64'(e.cnt));
        chk("d3_full",       64'(bus3.full),       64'(e.cnt == 3));
        $display("txn d3 idx=%0d valid=%0b data=0x%0h count=%0d", e.idx,
                 bus3.read_valid, bus3.read_data, bus3.count);
      end
    end
  end

  initial begin : stim
    bus4.write_enable = 1'b0; bus4.write_data = '0; bus4.flush = 1'b0; bus4.rd_index = '0;
    bus3.write_enable = 1'b0; bus3.write_data = '0; bus3.flush = 1'b0; bus3.rd_index = '0;
    reset = 1'b1;
    #2 reset = 1'b0;
    #1;
    chk("rst_read_valid", 64'(bus4.read_valid), 64'(0));
    chk("rst_read_data",  64'(bus4.read_data),  64'(0));
    chk("rst_count",      64'(bus4.count),      64'(0));
    chk("rst_full",       64'(bus4.full),       64'(0));
    @(negedge clk);
    reset = 1'b1;

    // Empty history: every age reads invalid.
    cyc4(0, 0, 0, 0, 0, 0, 0);
    cyc4(0, 0, 0, 3, 0, 0, 0);
    // Fill three entries while reading; same-cycle reads differ with forwarding.
    cyc4(1, 49'h1, 0, 0, BYP, BYP ? 49'h1 : 49'h0, 1);
    cyc4(1, 49'h2, 0, 1, BYP, BYP ? 49'h1 : 49'h0, 2);
    cyc4(1, 49'h3, 0, 0, 1, BYP ? 49'h3 : 49'h2, 3);
    cyc4(0, 0, 0, 0, 1, 49'h3, 3);
    cyc4(0, 0, 0, 1, 1, 49'h2, 3);
    cyc4(0, 0, 0, 2, 1, 49'h1, 3);
    cyc4(0, 0, 0, 3, 0, 49'h0, 3);
    // Wrap past full: oldest entries overwritten.
    cyc4(1, 49'h4, 0, 2, 1, BYP ? 49'h2 : 49'h1, 4);
    cyc4(1, 49'h5, 0, 3, 1, BYP ? 49'h2 : 49'h1, 4);
    cyc4(1, 49'h6, 0, 3, 1, BYP ? 49'h3 : 49'h2, 4);
    cyc4(0, 0, 0, 0, 1, 49'h6, 4);
    cyc4(0, 0, 0, 1, 1, 49'h5, 4);
    cyc4(0, 0, 0, 2, 1, 49'h4, 4);
    cyc4(0, 0, 0, 3, 1, 49'h3, 4);
    // Flush together with a write leaves one entry.
    cyc4(1, 49'h7, 1, 0, 1, BYP ? 49'h7 : 49'h6, 1);
    cyc4(0, 0, 0, 0, 1, 49'h7, 1);
    cyc4(0, 0, 0, 1, 0, 49'h0, 1);
    cyc4(1, 49'h1_8000_0000_0008, 0, 0, 1, BYP ? 49'h1_8000_0000_0008 : 49'h7, 2);
    // Flush only.
    cyc4(0, 0, 1, 0, !BYP, BYP ? 49'h0 : 49'h1_8000_0000_0008, 0);
    cyc4(0, 0, 0, 0, 0, 49'h0, 0);
    cyc4(1, 49'h11, 0, 0, BYP, BYP ? 49'h11 : 49'h0, 1);
    cyc4(1, 49'h9, 0, 0, 1, BYP ? 49'h9 : 49'h11, 2);
    cyc4(0, 0, 0, 1, 1, 49'h11, 2);

    // Asynchronous reset between edges, with a write pending.
    @(posedge clk);
    #3;
    bus4.write_enable = 1'b1;
    bus4.write_data   = 49'hFF;
    reset = 1'b0;
    #1;
    chk("midrst_read_valid", 64'(bus4.read_valid), 64'(0));
    chk("midrst_read_data",  64'(bus4.read_data),  64'(0));
    chk("midrst_count",      64'(bus4.count),      64'(0));
    chk("midrst_full",       64'(bus4.full),       64'(0));
    @(negedge clk);
    reset = 1'b1;
    bus4.write_enable = 1'b0;
    cyc4(0, 0, 0, 0, 0, 49'h0, 0);

    // DEPTH=3 instance: non-power-of-two wrap and out-of-range age.
    cyc3(1, 49'hA, 3, 0, 0, 1);
    cyc3(1, 49'hB, 3, 0, 0, 2);
    cyc3(1, 49'hC, 3, 0, 0, 3);
    cyc3(1, 49'hD, 3, 0, 0, 3);
    cyc3(1, 49'hE, 3, 0, 0, 3);
    cyc3(0, 0, 0, 1, 49'hE, 3);
    cyc3(0, 0, 1, 1, 49'hD, 3);
    cyc3(0, 0, 2, 1, 49'hC, 3);
    cyc3(0, 0, 3, 0, 49'h0, 3);
    cyc4(0, 0, 0, 0, 0, 49'h0, 0);

    @(posedge clk);
    #3;
    chk("scoreboard_drained", 64'(q4.size() + q3.size()), 64'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/last_instr_history.md
# last_instr_history

Parametrised history buffer holding the most recent DEPTH instruction words, generalising the single-entry last-instruction register. Sits beside the pipeline stage registers. Hazard, interrupt-return and debug logic read any of the last DEPTH retired or issued instructions by age index; the buffer supports flushing on branch/interrupt. All state updates occur on one clock edge, and the read port is registered.

## Interface
- WIDTH, 49, bits per stored instruction word
- DEPTH, 4, number of history entries; legal range 2..16; need not be a power of two
- IDXW, $clog2(DEPTH), width of age index and pointer (derived, not overridden)
- clk  in  1  clock; all state updates on posedge
- reset  in  1  asynchronous, active-low: 0 resets immediately, release synchronous to clk by the surrounding design
- write_enable  in  1  push write_data as newest entry this cycle
- write_data  in  WIDTH  instruction word to push
- flush  in  1  invalidate all history this cycle
- rd_index  in  IDXW  age of entry to read: 0 = newest, DEPTH-1 = oldest
- read_data  out  WIDTH  registered entry at rd_index; 0 when invalid
- read_valid  out  1  registered: the requested entry existed
- count  out  IDXW+1  number of valid entries, 0..DEPTH
- full  out  1  count == DEPTH

## Operation
- Storage: DEPTH×WIDTH array, write pointer wr_ptr (slot for next write), occupancy count.
- Write (write_enable=1, flush=0): mem[wr_ptr] <= write_data; wr_ptr <= (wr_ptr==DEPTH-1) ? 0 : wr_ptr+1; count <= min(count+1, DEPTH).
- Write when full: overwrites oldest entry; count stays DEPTH; no error.
- Flush only: count <= 0; wr_ptr unchanged; array contents not cleared.
- Flush and write in same cycle: flush applies first, then the write. Result: count=1, and the new word is at age 0.
- Read lookup: physical slot = (wr_ptr − 1 − rd_index) mod DEPTH. Computed with explicit wrap, by adding DEPTH before subtracting; no power-of-two masking.
- Read validity: valid = (rd_index < count), evaluated against pre-edge state. read_valid <= valid; read_data <= valid ? mem[slot] : 0.
- rd_index ≥ DEPTH (non-power-of-two DEPTH): read_valid=0, read_data=0.
- Reset (reset=0): wr_ptr=0, count=0, full=0, read_data=0, read_valid=0, all array entries=0. Asynchronous; aborts any in-flight write.

## Timing
- Single clock domain, single edge.
- Write-to-state latency: 1 cycle. count/full reflect a write at the following posedge.
- Read latency: 1 cycle. read_data/read_valid at edge N+1 reflect rd_index sampled at edge N, using history as it stood before edge N's write/flush. Read-before-write: see Configuration for the bypass exception.
- count and full are registered state outputs with no combinational input path.
- No handshake; write_enable is accepted every cycle it is high.

## Configuration
- LAST_INSTR_BYPASS_EN defined: write-through forwarding.
  - write_enable=1 and rd_index=0 in the same cycle: read_data <= write_data, read_valid <= 1, even if flush=1.
  - For rd_index>0 during a write, the lookup is shifted so the age is relative to the post-write history. Ages are consistent with the new entry being age 0. Validity uses the post-write count.
  - Flush without write: read_valid <= 0 that cycle.
- Not defined: pure read-before-write as in Operation; flush does not affect the read issued in the same cycle.

## Structure
- Package last_instr_pkg:
  - LAST_INSTR_WIDTH=49, LAST_INSTR_DEPTH=4 defaults
  - age-to-slot wrap function, shared with any debug reader
- One sub-module, last_instr_mem: DEPTH×WIDTH array with synchronous write, asynchronous read by slot, and async reset clear.
- Top level holds wr_ptr, count, lookup, output registers and the bypass mux.

## Test plan
- Reset then read all indices -> read_valid=0, read_data=0, count=0, full=0.
- Push 0x1, 0x2, 0x3 (DEPTH=4); read idx0/1/2/3 -> 0x3/0x2/0x1 valid; idx3 invalid with data 0; count=3.
- Push 0x1..0x6 (DEPTH=4) -> full=1, count=4; idx0..3 = 0x6,0x5,0x4,0x3; wr_ptr wrapped to 2.
- DEPTH=3 build: push 0xA..0xE; read idx0..2 = 0xE,0xD,0xC; idx3 -> invalid, data 0.
- Flush with write of 0x7 after full history -> count=1; idx0=0x7; idx1 invalid.
- Same cycle push 0x9 with rd_index=0: without macro -> returns previous newest; with LAST_INSTR_BYPASS_EN -> returns 0x9. Assert reset mid-sequence -> all outputs 0 before the next edge.
